// File: rtl/prog_clkdiv_pkg.sv
// Shared constants for the programmable clock divider.
package prog_clkdiv_pkg;

    localparam int CNT_W_DEF     = 15;     // half-period counter width
    localparam int HALF_INIT_DEF = 24999;  // 50 MHz -> 1 kHz half-period
    localparam int MAX_CHANNELS  = 8;
    localparam int LOAD_CH_W     = 3;      // width of the load channel index

    typedef logic [LOAD_CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/prog_clock_divider_div_channel.sv
// One divider channel: half-period counter, active/shadow half-period,
// pending flag, 50% duty output clock and rising-toggle tick.
module div_channel
    import prog_clkdiv_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int HALF_INIT = HALF_INIT_DEF
) (
    input  logic             clockin,
    input  logic             resetn,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clkout,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_INIT);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half_act;
    logic [CNT_W-1:0] half_shd;
    logic             tc;

    // Terminal count compares against the active half-period. The counter
    // never passes half_act, so the full 2^CNT_W-1 range cannot wrap early.
    assign tc = (count == half_act);

    // Counter, output clock, tick and half-period update logic.
    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            half_act <= HALF_RST;
            half_shd <= HALF_RST;
        end else if (!enable) begin
            // Idle: nothing is in flight, so new values take effect at once.
            count   <= '0;
            clkout  <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr_en) begin
                half_act <= wr_half;
            end else if (pending) begin
                half_act <= half_shd;
            end
        end else begin
            if (tc) begin
                count  <= '0;
                clkout <= ~clkout;
                tick   <= ~clkout;
                // Swap only at a half-period boundary so no half is distorted.
                if (pending) begin
                    half_act <= half_shd;
                    pending  <= 1'b0;
                end
            end else begin
                count <= count + 1'b1;
                tick  <= 1'b0;
            end
            // A load landing on a terminal count waits for the next one.
            if (wr_en) begin
                half_shd <= wr_half;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: load decode, load_ready muxing
// and one div_channel per channel.
module prog_clock_divider
    import prog_clkdiv_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int HALF_INIT = HALF_INIT_DEF
) (
    input  logic                 clockin,
    input  logic                 resetn,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 load_valid,
    input  logic [LOAD_CH_W-1:0] load_ch,
    input  logic [CNT_W-1:0]     load_half,
    output logic                 load_ready,
    output logic [CHANNELS-1:0]  clkout,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [LOAD_CH_W:0] CH_LIM = (LOAD_CH_W+1)'(CHANNELS);

    logic                    ch_valid;
    logic                    load_acc;
    logic [CHANNELS-1:0]     pending;
    logic [CHANNELS-1:0]     wr_en;
    logic [MAX_CHANNELS-1:0] pend_pad;

    assign ch_valid = ({1'b0, load_ch} < CH_LIM);

    // Widen the pending flags so any 3-bit index is in range.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pending;
    end

    // Out-of-range loads are always accepted and then dropped.
    assign load_ready = !ch_valid || !pend_pad[load_ch];
    assign load_acc   = load_valid && load_ready && ch_valid;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr_en[i] = load_acc && (load_ch == LOAD_CH_W'(i));

        div_channel #(
            .CNT_W     (CNT_W),
            .HALF_INIT (HALF_INIT)
        ) u_div (
            .clockin (clockin),
            .resetn  (resetn),
            .enable  (enable[i]),
            .wr_en   (wr_en[i]),
            .wr_half (load_half),
            .clkout  (clkout[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with a per-cycle expectation queue.
module tb_prog_clock_divider;

    localparam int CHANNELS  = 2;
    localparam int CNT_W     = 4;
    localparam int HALF_INIT = 3;

    logic                clockin = 1'b0;
    logic                resetn;
    logic [CHANNELS-1:0] enable;
    logic                load_valid;
    logic [2:0]          load_ch;
    logic [CNT_W-1:0]    load_half;
    logic                load_ready;
    logic [CHANNELS-1:0] clkout;
    logic [CHANNELS-1:0] tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base, s, d, f;

    typedef struct {
        int   cyc;
        int   ch;
        logic clk;
        logic tk;
    } exp_t;

    exp_t sb[$];

    prog_clock_divider #(
        .CHANNELS  (CHANNELS),
        .CNT_W     (CNT_W),
        .HALF_INIT (HALF_INIT)
    ) dut (
        .clockin    (clockin),
        .resetn     (resetn),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_half  (load_half),
        .load_ready (load_ready),
        .clkout     (clkout),
        .tick       (tick)
    );

    always #5 clockin = ~clockin;

    initial begin
        #100us;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push_const(input int ch, input int a, input int b, input logic v);
        for (int c = a; c <= b; c++) begin
            exp_t e;
            e.cyc = c; e.ch = ch; e.clk = v; e.tk = 1'b0;
            sb.push_back(e);
        end
    endtask

    // Segment that enters level l at edge s0, then toggles every h+1 edges.
    task automatic push_seg(input int ch, input int s0, input int h, input logic l, input int c_end);
        for (int c = s0; c <= c_end; c++) begin
            exp_t e;
            int   off;
            off   = c - s0;
            e.cyc = c;
            e.ch  = ch;
            e.clk = (((off / (h + 1)) % 2) == 1) ? ~l : l;
            e.tk  = e.clk && ((off % (h + 1)) == 0);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clockin);
        cyc++;
        @(negedge clockin);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                assert (clkout[sb[i].ch] === sb[i].clk) else begin
                    errors++;
                    $error("FAIL clkout cyc=%0d ch=%0d observed=%b expected=%b",
                           cyc, sb[i].ch, clkout[sb[i].ch], sb[i].clk);
                end
                checks++;
                assert (tick[sb[i].ch] === sb[i].tk) else begin
                    errors++;
                    $error("FAIL tick cyc=%0d ch=%0d observed=%b expected=%b",
                           cyc, sb[i].ch, tick[sb[i].ch], sb[i].tk);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        resetn     = 1'b0;
        enable     = '0;
        load_valid = 1'b0;
        load_ch    = '0;
        load_half  = '0;
        step();
        step();
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_tick",   32'(tick),   32'd0);
        chk("rst_ready",  32'(load_ready), 32'd1);

        // Both channels from reset with H=3: first rise on 4th enabled edge.
        resetn = 1'b1;
        enable = 2'b11;
        base   = cyc + 1;
        s      = base + 3;
        d      = s + 47;
        push_const(0, base, s - 1, 1'b0);
        push_const(1, base, s - 1, 1'b0);
        push_seg(0, s,      3, 1'b1, s + 27);
        push_seg(0, s + 28, 1, 1'b0, s + 35);
        push_seg(0, s + 36, 3, 1'b0, d);
        push_seg(1, s,      3, 1'b1, d);

        // Mid-period load H=1 on ch0: current half stays 4, then halves of 2.
        run_to(s + 25);
        chk("mid_ready_pre", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_ch = 3'd0; load_half = 4'd1;
        step();
        load_valid = 1'b0;
        chk("mid_ready_pend0", 32'(load_ready), 32'd0);
        step();
        chk("mid_ready_pend1", 32'(load_ready), 32'd0);
        step();
        chk("mid_ready_switch", 32'(load_ready), 32'd1);

        // Load H=3 accepted on a terminal-count edge: one more old half.
        run_to(s + 33);
        chk("tc_ready_pre", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_ch = 3'd0; load_half = 4'd3;
        step();
        load_valid = 1'b0;
        chk("tc_ready_pend0", 32'(load_ready), 32'd0);
        step();
        chk("tc_ready_pend1", 32'(load_ready), 32'd0);
        step();
        chk("tc_ready_switch", 32'(load_ready), 32'd1);

        // Disable both, load H=0 on ch0 and H=15 on ch1 directly, re-enable.
        run_to(d);
        enable = 2'b00;
        f      = d + 76;
        push_const(0, d + 1, d + 3,  1'b0);
        push_const(1, d + 1, d + 18, 1'b0);
        push_seg(0, d + 4,  0,  1'b1, f + 14);
        push_seg(1, d + 19, 15, 1'b1, f);
        step();
        load_valid = 1'b1; load_ch = 3'd0; load_half = 4'd0;
        step();
        chk("dis_ready_ch0", 32'(load_ready), 32'd1);
        load_ch = 3'd1; load_half = 4'd15;
        step();
        chk("dis_ready_ch1", 32'(load_ready), 32'd1);
        load_valid = 1'b0;
        enable     = 2'b11;

        // Out-of-range channel index: accepted and dropped.
        run_to(d + 66);
        load_valid = 1'b1; load_ch = 3'd5; load_half = 4'd2;
        chk("oor_ready", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        load_ch    = 3'd0;
        chk("oor_ready_ch0", 32'(load_ready), 32'd1);
        load_ch    = 3'd1;
        chk("oor_ready_ch1", 32'(load_ready), 32'd1);

        // ch1 disabled, load H=7, first rise 8 edges after enable.
        run_to(f);
        enable = 2'b01;
        push_const(1, f + 1, f + 9, 1'b0);
        push_seg(1, f + 10, 7, 1'b1, f + 14);
        step();
        load_valid = 1'b1; load_ch = 3'd1; load_half = 4'd7;
        step();
        chk("dis7_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b0;
        enable     = 2'b11;

        // Pending load on ch1, then asynchronous reset mid-period.
        run_to(f + 12);
        chk("rst_ready_pre", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_ch = 3'd1; load_half = 4'd2;
        step();
        load_valid = 1'b0;
        chk("rst_ready_pend0", 32'(load_ready), 32'd0);
        step();
        chk("rst_ready_pend1", 32'(load_ready), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_clkout", 32'(clkout), 32'd0);
        chk("async_tick",   32'(tick),   32'd0);
        chk("async_ready",  32'(load_ready), 32'd1);
        push_const(0, f + 15, f + 19, 1'b0);
        push_const(1, f + 15, f + 19, 1'b0);
        push_seg(0, f + 20, 3, 1'b1, f + 35);
        push_seg(1, f + 20, 3, 1'b1, f + 35);
        step();
        step();
        resetn = 1'b1;
        run_to(f + 35);
        chk("post_rst_ready", 32'(load_ready), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 15: half-period counter width.
REQ-003 SHALL have parameter HALF_INIT, default 24999: half-period value loaded at reset (50 MHz -> 1 kHz).
REQ-004 SHALL have port clockin  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  CHANNELS  per-channel run enable.
REQ-007 SHALL have port load_valid  input  1  request to write a new half-period.
REQ-008 SHALL have port load_ch  input  3  target channel index.
REQ-009 SHALL have port load_half  input  CNT_W  new half-period value H.
REQ-010 SHALL have port load_ready  output  1  load can be accepted this cycle.
REQ-011 SHALL have port clkout  output  CHANNELS  divided clocks, 50% duty.
REQ-012 SHALL have port tick  output  CHANNELS  one-cycle pulse on each clkout rising toggle.

Function
REQ-013 Each channel SHALL count 0..H and, on the cycle count==H, reset count to 0 and invert clkout, giving period 2*(H+1) clockin cycles.
REQ-014 H=0 SHALL give divide-by-2; H=2^CNT_W-1 SHALL count full range with no overflow or early wrap.
REQ-015 tick[i] SHALL be registered and high for exactly the one cycle in which clkout[i] is 1 following a 0->1 toggle.
REQ-016 A load SHALL be accepted when load_valid && load_ready on a rising edge.
REQ-017 load_ready SHALL be combinational: high when load_ch >= CHANNELS or when the addressed channel has no pending shadow value.
REQ-018 An accepted load to an enabled channel SHALL be stored in that channel's shadow register and set its pending flag; the active H is unchanged.
REQ-019 A pending shadow SHALL transfer to active H at the next terminal count (count==H), so no shortened or stretched half-period is produced; pending clears on that same edge.
REQ-020 A load accepted in the same cycle as a terminal count SHALL apply at the following terminal count, not the current one.
REQ-021 An accepted load to a disabled channel SHALL write active H directly, leaving pending clear.
REQ-022 An accepted load with load_ch >= CHANNELS SHALL be discarded with no state change.
REQ-023 enable[i] low SHALL hold count at 0, force clkout[i]=0 and tick[i]=0 on the next edge, and apply any pending shadow immediately.
REQ-024 On enable[i] rising, the first toggle (0->1, with tick) SHALL occur H+1 cycles after the first enabled edge.
REQ-025 Channels SHALL be fully independent; simultaneous terminal counts on several channels SHALL each behave as if alone.

Reset
REQ-026 resetn low SHALL asynchronously force count=0, clkout=0, tick=0, pending=0, active H=HALF_INIT and shadow=HALF_INIT on every channel.
REQ-027 Reset asserted mid-period SHALL discard any pending load; after release, channels restart per REQ-024 using HALF_INIT.
REQ-028 load_ready SHALL be high during and directly after reset.

Structure
REQ-029 Package prog_clkdiv_pkg SHALL hold default constants: CNT_W default, HALF_INIT default, maximum CHANNELS (8), and load_ch width (3).
REQ-030 One sub-module, div_channel (counter, active/shadow H, pending flag, clkout, tick), SHALL be instantiated CHANNELS times via generate; the top SHALL hold only load decode and load_ready muxing.

Verification
REQ-031 Reset release, enable=2'b11, H=HALF_INIT=3 (overridden) -> first clkout rise + tick at cycle 4, period 8 cycles, duty 4/4, both channels.
REQ-032 Ch0 running H=3; load H=1 mid-period -> current half stays 4 cycles, then halves of 2 cycles; load_ready for ch0 low from accept until switch.
REQ-033 Load to ch0 on the exact terminal-count edge -> old H used for one more half-period, new H thereafter.
REQ-034 H=0 -> clkout toggles every cycle, tick every 2nd cycle; CNT_W=4, H=15 -> 16-cycle halves, no overflow.
REQ-035 load_ch=5 with CHANNELS=2 -> load_ready=1, no channel changes; ch1 disabled, load H=7 -> applied immediately, first rise 8 cycles after enable.
REQ-036 resetn pulsed low mid-period with pending load -> outputs 0 asynchronously, pending dropped, restart with HALF_INIT.
